// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package ahb2apb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // One-hot APB slave selects
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_S0   = 3'b001;
  localparam logic [2:0] SEL_S1   = 3'b010;
  localparam logic [2:0] SEL_S2   = 3'b100;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RENABLE  = 3'd2,
    WWAIT    = 3'd3,
    WRITE    = 3'd4,
    WENABLE  = 3'd5,
    WRITEP   = 3'd6,
    WENABLEP = 3'd7
  } apb_state_e;

endpackage

// File: rtl/apb_fsm_controller.sv
// Sequences pipelined AHB transfers into APB SETUP/ENABLE cycles and
// stalls AHB through hready_out while an APB access is in flight.
module apb_fsm_controller
  import ahb2apb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  input  logic [2:0]        temp_selx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              penable,
  output logic [2:0]        pselx,
  output logic              hready_out
);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic [2:0]        r_selx_q;

  logic [ADDR_W-1:0] r_paddr,   w_paddr;
  logic [DATA_W-1:0] r_pwdata,  w_pwdata;
  logic              r_pwrite,  w_pwrite;
  logic              r_penable, w_penable;
  logic [2:0]        r_pselx,   w_pselx;
  logic              r_hready,  w_hready;
  logic              w_from_pipe;

  // Next-state selection from current state and AHB pipeline inputs
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RENABLE, WENABLE: begin
        if (valid && !hwrite)     w_next = READ;
        else if (valid && hwrite) w_next = WWAIT;
        else                      w_next = IDLE;
      end
      READ:     w_next = RENABLE;
      WWAIT:    w_next = valid ? WRITEP : WRITE;
      WRITE:    w_next = valid ? WENABLEP : WENABLE;
      WRITEP:   w_next = WENABLEP;
      WENABLEP: begin
        if (!hwrite_reg) w_next = READ;
        else if (valid)  w_next = WRITEP;
        else             w_next = WRITE;
      end
      default:  w_next = IDLE;
    endcase
  end

  // A write launched out of WENABLEP is one stage deeper in the AHB
  // pipeline than one launched out of WWAIT, so it uses the older taps.
  assign w_from_pipe = (r_state == WENABLEP);

  // Output values to be registered on entry to the next state
  always_comb begin
    w_paddr   = r_paddr;
    w_pwdata  = r_pwdata;
    w_pwrite  = r_pwrite;
    w_penable = 1'b0;
    w_pselx   = r_pselx;
    w_hready  = 1'b1;
    case (w_next)
      READ: begin
        w_paddr  = haddr;
        w_pselx  = temp_selx;
        w_pwrite = 1'b0;
        w_hready = 1'b0;
      end
      RENABLE, WENABLE, WENABLEP: begin
        w_penable = 1'b1;
      end
      WRITE, WRITEP: begin
        w_paddr  = w_from_pipe ? haddr2 : haddr1;
        w_pwdata = w_from_pipe ? hwdata1 : hwdata;
        w_pselx  = r_selx_q;
        w_pwrite = 1'b1;
        w_hready = 1'b0;
      end
      IDLE, WWAIT: begin
        w_pselx = SEL_NONE;
      end
      default: begin
        w_pselx = SEL_NONE;
      end
    endcase
  end

  // State, captured select and all APB/AHB outputs updated together
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state   <= IDLE;
      r_selx_q  <= SEL_NONE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_penable <= 1'b0;
      r_pselx   <= SEL_NONE;
      r_hready  <= 1'b1;
    end else begin
      r_state   <= w_next;
      if (valid) r_selx_q <= temp_selx;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
      r_pwrite  <= w_pwrite;
      r_penable <= w_penable;
      r_pselx   <= w_pselx;
      r_hready  <= w_hready;
    end
  end

  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign pwrite     = r_pwrite;
  assign penable    = r_penable;
  assign pselx      = r_pselx;
  assign hready_out = r_hready;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: scripted AHB pipeline stimulus, inline
// per-cycle checks and an APB-side scoreboard popped on every ENABLE.
module tb_apb_fsm_controller;
  import ahb2apb_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        valid = 1'b0;
  logic        hwrite = 1'b0;
  logic        hwrite_reg = 1'b0;
  logic [31:0] haddr = '0, haddr1 = '0, haddr2 = '0;
  logic [31:0] hwdata = '0, hwdata1 = '0;
  logic [2:0]  temp_selx;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable, hready_out;
  logic [2:0]  pselx;

  xfer_t sbq[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  prev_pen = 1'b0;

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite),
    .hwrite_reg(hwrite_reg), .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2),
    .hwdata(hwdata), .hwdata1(hwdata1), .temp_selx(temp_selx),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .penable(penable),
    .pselx(pselx), .hready_out(hready_out)
  );

  always #5 hclk = ~hclk;

  function automatic logic [2:0] decode(input logic [31:0] a);
    case (a[31:26])
      6'b100000: decode = SEL_S0;
      6'b100001: decode = SEL_S1;
      6'b100010: decode = SEL_S2;
      default:   decode = SEL_NONE;
    endcase
  endfunction

  assign temp_selx = decode(haddr);

  // Upstream AHB slave pipeline taps
  always @(posedge hclk) begin
    hwrite_reg <= hwrite;
    haddr1     <= haddr;
    haddr2     <= haddr1;
    hwdata1    <= hwdata;
  end

  // APB monitor: every ENABLE must match the oldest queued transfer
  always @(negedge hclk) begin
    if (penable) begin
      n_vec++;
      if (prev_pen) begin
        n_err++;
        $display("FAIL penable_double: got 2 consecutive cycles, want 1");
      end
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_enable: got ENABLE paddr=%h, want none", paddr);
      end else begin
        xfer_t e;
        e = sbq.pop_front();
        if (pwrite !== e.wr || paddr !== e.addr || pselx !== e.sel ||
            (e.wr && pwdata !== e.data)) begin
          n_err++;
          $display("FAIL enable_xfer: got wr=%b addr=%h data=%h sel=%b, want wr=%b addr=%h data=%h sel=%b",
                   pwrite, paddr, pwdata, pselx, e.wr, e.addr, e.data, e.sel);
        end
      end
    end
    prev_pen = penable;
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    valid  = v;
    hwrite = w;
    haddr  = a;
    hwdata = d;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.wr = w; x.addr = a; x.data = d; x.sel = decode(a);
    sbq.push_back(x);
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), $urandom, $urandom);
      tick();
    end
    n_vec++;
    if ({paddr, pwdata, pwrite, penable, pselx, hready_out} !== {64'h0, 1'b0, 1'b0, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: got paddr=%h pwdata=%h pw=%b pen=%b sel=%b rdy=%b, want 0/0/0/0/000/1",
               paddr, pwdata, pwrite, penable, pselx, hready_out);
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    hreset = 1'b0;
    tick();
    n_vec++;
    if (hready_out !== 1'b1 || pselx !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: got rdy=%b sel=%b, want 1/000", hready_out, pselx);
    end
  endtask

  task automatic test_single_read(input logic [31:0] a);
    drive(1'b1, 1'b0, a, '0);
    push(1'b0, a, '0);
    tick();
    n_vec++;
    if (pselx !== decode(a) || paddr !== a || penable !== 1'b0 || hready_out !== 1'b0 || pwrite !== 1'b0) begin
      n_err++;
      $display("FAIL read_setup: got sel=%b addr=%h pen=%b rdy=%b pw=%b, want sel=%b addr=%h pen=0 rdy=0 pw=0",
               pselx, paddr, penable, hready_out, pwrite, decode(a), a);
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    n_vec++;
    if (penable !== 1'b1 || hready_out !== 1'b1 || pselx !== decode(a)) begin
      n_err++;
      $display("FAIL read_enable: got pen=%b rdy=%b sel=%b, want 1/1/%b", penable, hready_out, pselx, decode(a));
    end
    tick();
    n_vec++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
      n_err++;
      $display("FAIL read_idle: got sel=%b pen=%b rdy=%b, want 000/0/1", pselx, penable, hready_out);
    end
  endtask

  task automatic test_single_write();
    drive(1'b1, 1'b1, 32'h8400_0004, '0);
    push(1'b1, 32'h8400_0004, 32'hDEAD_BEEF);
    tick();
    n_vec++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
      n_err++;
      $display("FAIL write_wwait: got sel=%b pen=%b rdy=%b, want 000/0/1", pselx, penable, hready_out);
    end
    drive(1'b0, 1'b1, '0, 32'hDEAD_BEEF);
    tick();
    n_vec++;
    if (pselx !== 3'b010 || paddr !== 32'h8400_0004 || pwdata !== 32'hDEAD_BEEF ||
        pwrite !== 1'b1 || penable !== 1'b0 || hready_out !== 1'b0) begin
      n_err++;
      $display("FAIL write_setup: got sel=%b addr=%h data=%h pw=%b pen=%b rdy=%b, want 010/84000004/deadbeef/1/0/0",
               pselx, paddr, pwdata, pwrite, penable, hready_out);
    end
    tick();
    n_vec++;
    if (penable !== 1'b1 || pselx !== 3'b010) begin
      n_err++;
      $display("FAIL write_enable: got pen=%b sel=%b, want 1/010", penable, pselx);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad [3];
    logic        rdy_exp [6];
    ad[0] = 32'h8800_0000; ad[1] = 32'h8800_0004; ad[2] = 32'h8800_0008;
    rdy_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) push(1'b1, ad[i], 32'(i + 1));
    drive(1'b1, 1'b1, ad[0], 32'd0);
    tick();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, 1'b1, ad[1], 32'd1);
        1: drive(1'b1, 1'b1, ad[2], 32'd2);
        2: drive(1'b1, 1'b1, ad[2], 32'd2);
        3: drive(1'b0, 1'b1, '0, 32'd3);
        4: drive(1'b0, 1'b1, '0, 32'd3);
        default: drive(1'b0, 1'b1, '0, '0);
      endcase
      tick();
      n_vec++;
      if (hready_out !== rdy_exp[c] || pselx !== 3'b100 || penable !== rdy_exp[c] || pwrite !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: got rdy=%b sel=%b pen=%b pw=%b, want %b/100/%b/1",
                 c, hready_out, pselx, penable, pwrite, rdy_exp[c], rdy_exp[c]);
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    n_vec++;
    if (pselx !== 3'b000 || hready_out !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_idle: got sel=%b rdy=%b, want 000/1", pselx, hready_out);
    end
  endtask

  task automatic test_write_then_read();
    push(1'b1, 32'h8000_0020, 32'hCAFE_0001);
    push(1'b0, 32'h8000_0024, '0);
    drive(1'b1, 1'b1, 32'h8000_0020, '0);
    tick();
    drive(1'b1, 1'b0, 32'h8000_0024, 32'hCAFE_0001);
    tick();
    n_vec++;
    if (paddr !== 32'h8000_0020 || pwdata !== 32'hCAFE_0001 || pwrite !== 1'b1 || hready_out !== 1'b0) begin
      n_err++;
      $display("FAIL wr_rd_wsetup: got addr=%h data=%h pw=%b rdy=%b, want 80000020/cafe0001/1/0",
               paddr, pwdata, pwrite, hready_out);
    end
    tick();
    tick();
    n_vec++;
    if (paddr !== 32'h8000_0024 || pwrite !== 1'b0 || penable !== 1'b0 ||
        pselx !== 3'b001 || hready_out !== 1'b0) begin
      n_err++;
      $display("FAIL wr_rd_rsetup: got addr=%h pw=%b pen=%b sel=%b rdy=%b, want 80000024/0/0/001/0",
               paddr, pwrite, penable, pselx, hready_out);
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    drive(1'b1, 1'b1, 32'h8400_0008, '0);
    tick();
    drive(1'b0, 1'b1, '0, 32'h0000_55AA);
    tick();
    n_vec++;
    if (pwrite !== 1'b1 || hready_out !== 1'b0 || pselx !== 3'b010) begin
      n_err++;
      $display("FAIL rst_mid_setup: got pw=%b rdy=%b sel=%b, want 1/0/010", pwrite, hready_out, pselx);
    end
    hreset = 1'b1;
    tick();
    n_vec++;
    if (penable !== 1'b0 || pselx !== 3'b000 || hready_out !== 1'b1 || paddr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_abort: got pen=%b sel=%b rdy=%b addr=%h, want 0/000/1/0",
               penable, pselx, hready_out, paddr);
    end
    hreset = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (penable !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_no_enable%0d: got pen=%b, want 0", i, penable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read(32'h8000_0010);
    test_single_write();
    test_back_to_back();
    test_write_then_read();
    test_single_read(32'h9000_0000);
    test_reset_mid_transfer();
    tick();
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending transfers, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
